mem_port_arbiter: RTL and testbench

- Shares one split-handshake memory port (address phase, then data phase) between the fetch stage and the mem stage of the 5-stage MIPS pipeline.
- Sequences one outstanding transaction at a time and returns read data with a one-cycle done pulse.
- Requesters hold their request high and stall until their done pulse.
- The hazard unit ORs ~inst_data_ok and ~data_data_ok into stallF/stallE.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch-side, mem-stage-side and memory-side signals that meet
// at the shared memory port. The arbiter takes the master view; the CPU stages
// and the memory together form the slave view.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // Fetch stage
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          inst_data_ok;

    // Mem stage
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          data_data_ok;

    // Memory port
    logic          mem_req;
    logic          mem_wr;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok;
    logic          mem_data_ok;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_rdata, inst_data_ok,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_data_ok,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_rdata, inst_data_ok,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_data_ok,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one split-handshake memory port (address phase, then data phase)
// between the fetch stage and the mem stage. One transaction is in flight at a
// time; completion returns registered read data with a one-cycle done pulse.
module mem_port_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    localparam logic [1:0] SizeWord = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StIAddr,
        StIData,
        StDAddr,
        StDData
    } state_e;

    // Registered state
    state_e        r_state;
    logic          r_last_grant;   // 0: inst granted last, 1: data granted last
    logic          r_wr;
    logic [1:0]    r_size;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_inst_rdata;
    logic [DW-1:0] r_data_rdata;
    logic          r_inst_ok;
    logic          r_data_ok;

    // Next-state values
    state_e        w_state_d;
    logic          w_last_grant_d;
    logic          w_wr_d;
    logic [1:0]    w_size_d;
    logic [AW-1:0] w_addr_d;
    logic [DW-1:0] w_wdata_d;
    logic [DW-1:0] w_inst_rdata_d;
    logic [DW-1:0] w_data_rdata_d;
    logic          w_inst_ok_d;
    logic          w_data_ok_d;

    // A requester still holding req during its own done cycle must not be
    // granted again; its done pulse masks its request.
    logic w_inst_valid;
    logic w_data_valid;
    logic w_grant_data;

    assign w_inst_valid = bus.inst_req & ~r_inst_ok;
    assign w_data_valid = bus.data_req & ~r_data_ok;

    // Data wins a tie unless it was also the previous winner.
    assign w_grant_data = w_data_valid & (~w_inst_valid | ~r_last_grant);

    // Next-state logic: grant, address phase, data phase, completion
    always_comb begin
        w_state_d      = r_state;
        w_last_grant_d = r_last_grant;
        w_wr_d         = r_wr;
        w_size_d       = r_size;
        w_addr_d       = r_addr;
        w_wdata_d      = r_wdata;
        w_inst_rdata_d = r_inst_rdata;
        w_data_rdata_d = r_data_rdata;
        w_inst_ok_d    = 1'b0;
        w_data_ok_d    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_grant_data) begin
                    w_state_d      = StDAddr;
                    w_last_grant_d = 1'b1;
                    w_wr_d         = bus.data_wr;
                    w_size_d       = bus.data_size;
                    w_addr_d       = bus.data_addr;
                    w_wdata_d      = bus.data_wdata;
                end else if (w_inst_valid) begin
                    w_state_d      = StIAddr;
                    w_last_grant_d = 1'b0;
                    w_wr_d         = 1'b0;
                    w_size_d       = SizeWord;
                    w_addr_d       = bus.inst_addr;
                    w_wdata_d      = '0;
                end
            end

            StIAddr: begin
                if (bus.mem_addr_ok) begin
                    if (bus.mem_data_ok) begin
                        // Both phases finished in the same cycle
                        w_state_d      = StIdle;
                        w_inst_rdata_d = bus.mem_rdata;
                        w_inst_ok_d    = 1'b1;
                    end else begin
                        w_state_d = StIData;
                    end
                end
            end

            StIData: begin
                if (bus.mem_data_ok) begin
                    w_state_d      = StIdle;
                    w_inst_rdata_d = bus.mem_rdata;
                    w_inst_ok_d    = 1'b1;
                end
            end

            StDAddr: begin
                if (bus.mem_addr_ok) begin
                    if (bus.mem_data_ok) begin
                        w_state_d      = StIdle;
                        w_data_rdata_d = bus.mem_rdata;
                        w_data_ok_d    = 1'b1;
                    end else begin
                        w_state_d = StDData;
                    end
                end
            end

            StDData: begin
                if (bus.mem_data_ok) begin
                    // Stores also capture mem_rdata; its value is meaningless
                    w_state_d      = StIdle;
                    w_data_rdata_d = bus.mem_rdata;
                    w_data_ok_d    = 1'b1;
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b0;
            r_wr         <= 1'b0;
            r_size       <= 2'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_ok    <= 1'b0;
            r_data_ok    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_last_grant <= w_last_grant_d;
            r_wr         <= w_wr_d;
            r_size       <= w_size_d;
            r_addr       <= w_addr_d;
            r_wdata      <= w_wdata_d;
            r_inst_rdata <= w_inst_rdata_d;
            r_data_rdata <= w_data_rdata_d;
            r_inst_ok    <= w_inst_ok_d;
            r_data_ok    <= w_data_ok_d;
        end
    end

    // Attribute lines come straight from the latches so they stay stable for
    // the whole address phase.
    assign bus.mem_req      = (r_state == StIAddr) || (r_state == StDAddr);
    assign bus.mem_wr       = r_wr;
    assign bus.mem_size     = r_size;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_wdata    = r_wdata;
    assign bus.inst_rdata   = r_inst_rdata;
    assign bus.inst_data_ok = r_inst_ok;
    assign bus.data_rdata   = r_data_rdata;
    assign bus.data_data_ok = r_data_ok;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both CPU stages and the
// memory, driving inputs 1 time unit after each rising edge and sampling there.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_req    = 1'b0;
        bus.inst_addr   = '0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_size   = 2'd0;
        bus.data_addr   = '0;
        bus.data_wdata  = '0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata} !== 68'h0) begin
            failures++;
            $display("FAIL reset_mem_outputs: got %h want 0",
                     {bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if ({bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata, bus.data_rdata} !== 66'h0) begin
            failures++;
            $display("FAIL reset_cpu_outputs: got %h want 0",
                     {bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata, bus.data_rdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0_0000;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_grant_cycle: got mem_req=%b want 0", bus.mem_req);
        end
        tick();
        checks++;
        if ({bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata}
            !== {1'b1, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0}) begin
            failures++;
            $display("FAIL fetch_addr_phase: got %h want %h",
                     {bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata},
                     {1'b1, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0});
        end
        bus.mem_addr_ok = 1'b1;
        tick();
        bus.mem_addr_ok = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_req_one_cycle: got mem_req=%b want 0", bus.mem_req);
        end
        tick();
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h3C08_8000;
        checks++;
        if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) begin
            failures++;
            $display("FAIL fetch_no_early_done: got %b want 00",
                     {bus.inst_data_ok, bus.data_data_ok});
        end
        tick();
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        bus.inst_req    = 1'b0;
        checks++;
        if ({bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata} !== {2'b10, 32'h3C08_8000}) begin
            failures++;
            $display("FAIL fetch_done: got %h want %h",
                     {bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata}, {2'b10, 32'h3C08_8000});
        end
        tick();
        checks++;
        if ({bus.inst_data_ok, bus.mem_req} !== 2'b00) begin
            failures++;
            $display("FAIL fetch_single_pulse: got %b want 00", {bus.inst_data_ok, bus.mem_req});
        end
    endtask

    task automatic test_simultaneous();
        bus.inst_req   = 1'b1;
        bus.inst_addr  = 32'hBFC0_0004;
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd2;
        bus.data_addr  = 32'h8000_1000;
        bus.data_wdata = 32'h0;
        tick();
        checks++;
        if ({bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata}
            !== {1'b1, 1'b0, 2'd2, 32'h8000_1000, 32'h0}) begin
            failures++;
            $display("FAIL simul_data_first: got %h want %h",
                     {bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata},
                     {1'b1, 1'b0, 2'd2, 32'h8000_1000, 32'h0});
        end
        bus.mem_addr_ok = 1'b1;
        tick();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'hCAFE_F00D;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL simul_data_phase_req: got mem_req=%b want 0", bus.mem_req);
        end
        tick();
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        checks++;
        if ({bus.inst_data_ok, bus.data_data_ok, bus.mem_req, bus.data_rdata}
            !== {3'b010, 32'hCAFE_F00D}) begin
            failures++;
            $display("FAIL simul_data_done: got %h want %h",
                     {bus.inst_data_ok, bus.data_data_ok, bus.mem_req, bus.data_rdata},
                     {3'b010, 32'hCAFE_F00D});
        end
        bus.data_req = 1'b0;
        tick();
        checks++;
        if ({bus.data_data_ok, bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata}
            !== {1'b0, 1'b1, 1'b0, 2'd2, 32'hBFC0_0004, 32'h0}) begin
            failures++;
            $display("FAIL simul_inst_second: got %h want %h",
                     {bus.data_data_ok, bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr,
                      bus.mem_wdata}, {1'b0, 1'b1, 1'b0, 2'd2, 32'hBFC0_0004, 32'h0});
        end
        bus.mem_addr_ok = 1'b1;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h27BD_FFE0;
        tick();
        idle_inputs();
        checks++;
        if ({bus.inst_data_ok, bus.data_data_ok, bus.mem_req, bus.inst_rdata, bus.data_rdata}
            !== {3'b100, 32'h27BD_FFE0, 32'hCAFE_F00D}) begin
            failures++;
            $display("FAIL simul_inst_done: got %h want %h",
                     {bus.inst_data_ok, bus.data_data_ok, bus.mem_req, bus.inst_rdata,
                      bus.data_rdata}, {3'b100, 32'h27BD_FFE0, 32'hCAFE_F00D});
        end
        tick();
    endtask

    task automatic test_store();
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_size  = 2'd0;
        bus.data_addr  = 32'h8000_0003;
        bus.data_wdata = 32'h0000_00AB;
        tick();
        // Three address-phase cycles without addr_ok; a stray data_ok in the
        // first must be ignored.
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.data_data_ok, bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr,
                 bus.mem_wdata} !== {1'b0, 1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB}) begin
                failures++;
                $display("FAIL store_hold_%0d: got %h want %h", i,
                         {bus.data_data_ok, bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr,
                          bus.mem_wdata}, {1'b0, 1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB});
            end
            bus.mem_data_ok = (i == 0);
            bus.mem_rdata   = (i == 0) ? 32'hFFFF_FFFF : 32'h0;
            tick();
        end
        checks++;
        if ({bus.data_data_ok, bus.mem_req, bus.mem_wr, bus.mem_addr}
            !== {1'b0, 1'b1, 1'b1, 32'h8000_0003}) begin
            failures++;
            $display("FAIL store_still_addr: got %h want %h",
                     {bus.data_data_ok, bus.mem_req, bus.mem_wr, bus.mem_addr},
                     {1'b0, 1'b1, 1'b1, 32'h8000_0003});
        end
        bus.mem_addr_ok = 1'b1;
        tick();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'hDEAD_BEEF;
        checks++;
        if ({bus.mem_req, bus.data_data_ok} !== 2'b00) begin
            failures++;
            $display("FAIL store_data_phase: got %b want 00", {bus.mem_req, bus.data_data_ok});
        end
        tick();
        idle_inputs();
        checks++;
        if ({bus.data_data_ok, bus.data_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL store_done: got %h want %h",
                     {bus.data_data_ok, bus.data_rdata}, {1'b1, 32'hDEAD_BEEF});
        end
        tick();
    endtask

    task automatic test_same_cycle();
        bus.data_req  = 1'b1;
        bus.data_wr   = 1'b0;
        bus.data_size = 2'd1;
        bus.data_addr = 32'h8000_2002;
        tick();
        checks++;
        if ({bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata}
            !== {1'b1, 1'b0, 2'd1, 32'h8000_2002, 32'h0}) begin
            failures++;
            $display("FAIL same_addr_phase: got %h want %h",
                     {bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata},
                     {1'b1, 1'b0, 2'd1, 32'h8000_2002, 32'h0});
        end
        bus.mem_addr_ok = 1'b1;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h1234_5678;
        tick();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        checks++;
        if ({bus.inst_data_ok, bus.data_data_ok, bus.mem_req, bus.data_rdata}
            !== {3'b010, 32'h1234_5678}) begin
            failures++;
            $display("FAIL same_done: got %h want %h",
                     {bus.inst_data_ok, bus.data_data_ok, bus.mem_req, bus.data_rdata},
                     {3'b010, 32'h1234_5678});
        end
        // data_req still held through the done cycle
        tick();
        bus.data_req = 1'b0;
        checks++;
        if ({bus.mem_req, bus.data_data_ok} !== 2'b00) begin
            failures++;
            $display("FAIL same_back_idle: got %b want 00", {bus.mem_req, bus.data_data_ok});
        end
        tick();
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL same_no_reissue: got mem_req=%b want 0", bus.mem_req);
        end
    endtask

    task automatic test_no_double_issue();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0_0008;
        tick();
        checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'hBFC0_0008}) begin
            failures++;
            $display("FAIL nodbl_addr_phase: got %h want %h",
                     {bus.mem_req, bus.mem_addr}, {1'b1, 32'hBFC0_0008});
        end
        bus.mem_addr_ok = 1'b1;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h8FA4_0000;
        tick();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        checks++;
        if ({bus.inst_data_ok, bus.inst_rdata} !== {1'b1, 32'h8FA4_0000}) begin
            failures++;
            $display("FAIL nodbl_done: got %h want %h",
                     {bus.inst_data_ok, bus.inst_rdata}, {1'b1, 32'h8FA4_0000});
        end
        // inst_req stays high for the done cycle, then drops
        tick();
        bus.inst_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bus.mem_req, bus.inst_data_ok} !== 2'b00) begin
                failures++;
                $display("FAIL nodbl_quiet_%0d: got %b want 00", i,
                         {bus.mem_req, bus.inst_data_ok});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr [3];
        exp_addr[0]    = 32'h8000_4000;
        exp_addr[1]    = 32'hBFC0_0010;
        exp_addr[2]    = 32'h8000_4000;
        bus.inst_req   = 1'b1;
        bus.inst_addr  = 32'hBFC0_0010;
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd2;
        bus.data_addr  = 32'h8000_4000;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bus.mem_req, bus.mem_addr} !== {1'b1, exp_addr[k]}) begin
                failures++;
                $display("FAIL b2b_grant_%0d: got %h want %h", k,
                         {bus.mem_req, bus.mem_addr}, {1'b1, exp_addr[k]});
            end
            bus.mem_addr_ok = 1'b1;
            bus.mem_data_ok = 1'b1;
            bus.mem_rdata   = 32'h0000_1000 + k;
            tick();
            bus.mem_addr_ok = 1'b0;
            bus.mem_data_ok = 1'b0;
            checks++;
            if ({bus.inst_data_ok, bus.data_data_ok} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL b2b_done_%0d: got %b want %b", k,
                         {bus.inst_data_ok, bus.data_data_ok}, (k % 2 == 1) ? 2'b10 : 2'b01);
            end
            if (k == 2) begin
                bus.inst_req = 1'b0;
                bus.data_req = 1'b0;
            end
            tick();
        end
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end_idle: got mem_req=%b want 0", bus.mem_req);
        end
    endtask

    task automatic test_reset_mid();
        bus.data_req  = 1'b1;
        bus.data_wr   = 1'b0;
        bus.data_size = 2'd2;
        bus.data_addr = 32'h8000_3000;
        tick();
        bus.mem_addr_ok = 1'b1;
        tick();
        bus.mem_addr_ok = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.data_req = 1'b0;
        checks++;
        if ({bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata} !== 68'h0) begin
            failures++;
            $display("FAIL rstmid_mem_outputs: got %h want 0",
                     {bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if ({bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata, bus.data_rdata} !== 66'h0) begin
            failures++;
            $display("FAIL rstmid_cpu_outputs: got %h want 0",
                     {bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata, bus.data_rdata});
        end
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h5555_5555;
        tick();
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bus.inst_data_ok, bus.data_data_ok, bus.mem_req, bus.data_rdata} !== 35'h0) begin
                failures++;
                $display("FAIL rstmid_stray_%0d: got %h want 0", i,
                         {bus.inst_data_ok, bus.data_data_ok, bus.mem_req, bus.data_rdata});
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_store();
        test_same_cycle();
        test_no_double_issue();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
